rv32lsm_memory: RTL

//  Memory-stage half of the RV32 load/store-multiple RISC-MGMT extension (LWM/SWM).

---
 rtl/rv32lsm_pkg.sv | 35 +++
 rtl/rv32lsm_memory.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rv32lsm_pkg.sv
// Shared types for the RV32 load/store-multiple extension memory stage.
// Cause codes are architecturally visible and must keep this order.
package rv32lsm_pkg;

    localparam int unsigned WORD_BYTES    = 4;
    localparam int unsigned MAX_WORDS_DEF = 8;
    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned CNT_W_DEF     = $clog2(MAX_WORDS_DEF + 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDrain,
        StErr
    } state_t;

    typedef enum logic [1:0] {
        CauseNone,
        CauseMisalign,
        CauseBadCnt,
        CauseAddrWrap
    } cause_t;

    // Execute-to-memory descriptor in the default configuration.
    typedef struct packed {
        logic                                 valid;
        logic                                 is_store;
        logic [ADDR_W_DEF-1:0]                base;
        logic [CNT_W_DEF-1:0]                 count;
        logic [4:0]                           rd_base;
        logic [MAX_WORDS_DEF*DATA_W_DEF-1:0]  sdata;
    } execute_memory_t;

endpackage

// File: rtl/rv32lsm_memory.sv
// Memory-stage sequencer for LWM/SWM: validates a burst descriptor, then issues one
// word access per beat and writes loaded words back to consecutive registers.
module rv32lsm_memory
    import rv32lsm_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_nrst,
    input  logic                        i_ex_valid,
    input  logic                        i_ex_is_store,
    input  logic [ADDR_W-1:0]           i_ex_base,
    input  logic [CNT_W-1:0]            i_ex_count,
    input  logic [4:0]                  i_ex_rd_base,
    input  logic [MAX_WORDS*DATA_W-1:0] i_ex_sdata,
    input  logic                        i_flush,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic                        o_mem_ren,
    output logic                        o_mem_wen,
    output logic [DATA_W-1:0]           o_mem_store,
    output logic [DATA_W/8-1:0]         o_mem_byte_en,
    input  logic [DATA_W-1:0]           i_mem_load,
    input  logic                        i_mem_busy,
    output logic                        o_busy,
    output logic                        o_reg_w,
    output logic [4:0]                  o_reg_rd,
    output logic [DATA_W-1:0]           o_reg_wdata,
    output logic                        o_exception,
    output logic [1:0]                  o_exception_cause
);

    state_t                        r_state;
    state_t                        w_state_next;
    cause_t                        r_cause;
    cause_t                        w_cause_next;
    logic                          r_is_store;
    logic [ADDR_W-1:0]             r_addr;
    logic [CNT_W-1:0]              r_count;
    logic [CNT_W-1:0]              r_idx;
    logic [4:0]                    r_rd_base;
    logic [MAX_WORDS*DATA_W-1:0]   r_sdata;
    logic                          r_reg_w;
    logic [4:0]                    r_reg_rd;
    logic [DATA_W-1:0]             r_reg_wdata;

    logic                          w_accept;
    logic                          w_beat_done;
    logic                          w_last;
    logic [4:0]                    w_rd;
    logic [CNT_W-1:0]              w_cnt_m1;
    logic [ADDR_W:0]               w_end;
    logic                          w_wrap;

    assign w_accept    = (r_state == StIdle) && i_ex_valid && !i_flush;
    assign w_beat_done = (r_state == StAccess) && !i_mem_busy && !i_flush;
    assign w_last      = (r_idx == r_count - CNT_W'(1));
    assign w_rd        = r_rd_base + 5'(r_idx);

    // Byte address of the final word, one bit wider so a carry marks wrap-around.
    assign w_cnt_m1 = i_ex_count - CNT_W'(1);
    assign w_end    = {1'b0, i_ex_base} + ({{(ADDR_W + 1 - CNT_W){1'b0}}, w_cnt_m1} << 2);
    assign w_wrap   = (i_ex_count != '0) && w_end[ADDR_W];

    always_comb begin
        w_state_next = r_state;
        w_cause_next = r_cause;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (i_ex_base[1:0] != 2'b00) begin
                        w_state_next = StErr;
                        w_cause_next = CauseMisalign;
                    end else if (i_ex_count > CNT_W'(MAX_WORDS)) begin
                        w_state_next = StErr;
                        w_cause_next = CauseBadCnt;
                    end else if (w_wrap) begin
                        w_state_next = StErr;
                        w_cause_next = CauseAddrWrap;
                    end else if (i_ex_count == '0) begin
                        w_state_next = StDrain;
                    end else begin
                        w_state_next = StAccess;
                    end
                end
            end
            StAccess: begin
                if (w_beat_done && w_last) begin
                    w_state_next = StDrain;
                end
            end
            StDrain:  w_state_next = StIdle;
            StErr:    w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
        if (i_flush) begin
            w_state_next = StIdle;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state     <= StIdle;
            r_cause     <= CauseNone;
            r_is_store  <= 1'b0;
            r_addr      <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_rd_base   <= '0;
            r_sdata     <= '0;
            r_reg_w     <= 1'b0;
            r_reg_rd    <= '0;
            r_reg_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_cause <= w_cause_next;
            if (w_accept) begin
                r_is_store <= i_ex_is_store;
                r_addr     <= i_ex_base;
                r_count    <= i_ex_count;
                r_idx      <= '0;
                r_rd_base  <= i_ex_rd_base;
                r_sdata    <= i_ex_sdata;
            end else if (w_beat_done) begin
                r_idx  <= r_idx + CNT_W'(1);
                r_addr <= r_addr + ADDR_W'(WORD_BYTES);
            end
            // x0 is hardwired zero, so its writeback is never raised.
            r_reg_w <= w_beat_done && !r_is_store && (w_rd != 5'd0);
            if (w_beat_done && !r_is_store) begin
                r_reg_rd    <= w_rd;
                r_reg_wdata <= i_mem_load;
            end
        end
    end

    assign o_mem_addr        = r_addr;
    assign o_mem_ren         = (r_state == StAccess) && !r_is_store && !i_flush;
    assign o_mem_wen         = (r_state == StAccess) && r_is_store && !i_flush;
    assign o_mem_store       = r_sdata[32'(r_idx) * DATA_W +: DATA_W];
    assign o_mem_byte_en     = '1;
    assign o_busy            = (r_state != StIdle) || (i_ex_valid && !i_flush);
    assign o_reg_w           = r_reg_w && !i_flush;
    assign o_reg_rd          = r_reg_rd;
    assign o_reg_wdata       = r_reg_wdata;
    assign o_exception       = (r_state == StErr) && !i_flush;
    assign o_exception_cause = o_exception ? r_cause : CauseNone;

endmodule
